// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: pipeline-side status in, PC / IF/ID / ID/EX controls out.
// master = pipeline datapath, slave = fetch_ctrl.
interface fetch_ctrl_if #(
  parameter int PC_W = 32
) ();
  logic [PC_W-1:0] pc_cur;
  logic            pcsrc;
  logic [PC_W-1:0] branch_add;
  logic            jump;
  logic [25:0]     jump_add;
  logic            imem_ready;
  logic            idex_memread;
  logic [4:0]      idex_rt;
  logic [4:0]      ifid_rs;
  logic [4:0]      ifid_rt;
  logic            pc_we;
  logic [PC_W-1:0] pc_next;
  logic            ifid_we;
  logic            ifid_flush;
  logic            idex_flush;
  logic            idex_bubble;
  logic            fetch_err;
  logic [1:0]      state;

  modport master (
    output pc_cur, pcsrc, branch_add, jump, jump_add,
    output imem_ready, idex_memread, idex_rt, ifid_rs, ifid_rt,
    input  pc_we, pc_next, ifid_we, ifid_flush,
    input  idex_flush, idex_bubble, fetch_err, state
  );

  modport slave (
    input  pc_cur, pcsrc, branch_add, jump, jump_add,
    input  imem_ready, idex_memread, idex_rt, ifid_rs, ifid_rt,
    output pc_we, pc_next, ifid_we, ifid_flush,
    output idex_flush, idex_bubble, fetch_err, state
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencing: PC update arbitration (branch > jump > pending > load-use > seq),
// slow-imem wait with held redirect, watchdog. Ports: clk, rst, bus (fetch_ctrl_if.slave);
// `FETCH_PERF_CNT_EN adds stall_cnt / flush_cnt outputs.
module fetch_ctrl #(
  parameter int PC_W    = 32,
  parameter int TIMEOUT = 15
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  fetch_ctrl_if.slave bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_TO = WC_W'(TIMEOUT);

  state_t          st, st_n;
  logic            pend_valid, pend_valid_n;
  logic            pend_br, pend_br_n;
  logic [PC_W-1:0] pend_tgt, pend_tgt_n;
  logic [WC_W-1:0] wait_cnt, wait_cnt_n;
  logic            err_q, err_n;

  logic [PC_W-1:0] jtgt, seq, tgt;
  logic            use_br, use_j, use_p, redir, hazard;
  logic            pc_we, ifid_we, ifid_flush, idex_flush, idex_bubble;
  logic [PC_W-1:0] pc_next;

  always_comb begin
    jtgt   = {bus.pc_cur[PC_W-1:28], bus.jump_add, 2'b00};
    seq    = bus.pc_cur + PC_W'(1);
    use_br = bus.pcsrc;
    // a held branch target outranks a later jump
    use_j  = bus.jump & ~bus.pcsrc & ~(pend_valid & pend_br);
    use_p  = pend_valid & ~use_br & ~use_j;
    redir  = use_br | use_j | use_p;
    if (use_br)     tgt = bus.branch_add;
    else if (use_j) tgt = jtgt;
    else if (use_p) tgt = pend_tgt;
    else            tgt = seq;
    hazard = (st == RUN) & ~redir & bus.idex_memread
           & (bus.idex_rt != 5'd0)
           & ((bus.idex_rt == bus.ifid_rs) | (bus.idex_rt == bus.ifid_rt));
  end

  always_comb begin
    pc_we        = 1'b0;
    pc_next      = '0;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    idex_bubble  = 1'b0;
    st_n         = st;
    pend_valid_n = pend_valid;
    pend_br_n    = pend_br;
    pend_tgt_n   = pend_tgt;
    wait_cnt_n   = '0;
    err_n        = err_q;
    if (hazard) begin
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      st_n        = STALL;
    end else begin
      // no valid instruction is available without imem_ready
      ifid_flush = redir | ~bus.imem_ready;
      idex_flush = use_br;
      if (bus.imem_ready) begin
        pc_we        = 1'b1;
        pc_next      = tgt;
        pend_valid_n = 1'b0;
        pend_br_n    = 1'b0;
        st_n         = RUN;
      end else begin
        st_n = WAIT;
        if (redir) begin
          pend_valid_n = 1'b1;
          pend_tgt_n   = tgt;
          pend_br_n    = use_br | (use_p & pend_br);
        end
        if (st == WAIT) begin
          wait_cnt_n = (wait_cnt == '1) ? wait_cnt : wait_cnt + WC_W'(1);
          if (wait_cnt_n >= WC_TO) err_n = 1'b1;
        end
      end
    end
    if (rst) begin
      pc_we       = 1'b0;
      pc_next     = '0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= RUN;
      pend_valid <= 1'b0;
      pend_br    <= 1'b0;
      pend_tgt   <= '0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      st         <= st_n;
      pend_valid <= pend_valid_n;
      pend_br    <= pend_br_n;
      pend_tgt   <= pend_tgt_n;
      wait_cnt   <= wait_cnt_n;
      err_q      <= err_n;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.pc_next     = pc_next;
  assign bus.ifid_we     = ifid_we;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.fetch_err   = err_q;
  assign bus.state       = st;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((idex_bubble | (st == WAIT)) && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((use_br | use_j) && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver queues expected outputs,
// negedge monitor pops and compares.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fetch_ctrl_if #(.PC_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
  fetch_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
`else
  fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  flags;
    logic        chk_pc;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic [7:0] act;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_flush,
             bus.idex_bubble, bus.fetch_err, bus.state};
      total++;
      if (act !== e.flags) begin
        bad++;
        $display("FAIL %s flags act=%b exp=%b", e.name, act, e.flags);
      end
      if (e.chk_pc) begin
        total++;
        if (bus.pc_next !== e.pc) begin
          bad++;
          $display("FAIL %s pc_next act=%h exp=%h", e.name, bus.pc_next, e.pc);
        end
      end
    end
  end

  task automatic set_def();
    bus.pcsrc        = 1'b0;
    bus.branch_add   = '0;
    bus.jump         = 1'b0;
    bus.jump_add     = '0;
    bus.imem_ready   = 1'b1;
    bus.idex_memread = 1'b0;
    bus.idex_rt      = '0;
    bus.ifid_rs      = '0;
    bus.ifid_rt      = '0;
  endtask

  // flags: pc_we ifid_we ifid_flush idex_flush idex_bubble fetch_err state
  task automatic cyc(input string nm, input logic we, input logic fw,
                     input logic ff, input logic xf, input logic bb,
                     input logic er, input logic [1:0] st,
                     input logic [31:0] pcn);
    exp_t x;
    x.name   = nm;
    x.flags  = {we, fw, ff, xf, bb, er, st};
    x.chk_pc = we | rst;
    x.pc     = pcn;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_def();
    bus.pc_cur = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 0, 0, 1, 0, 1, 0, 2'd0, 32'd0);
    rst = 1'b0;
    bus.pc_cur = 32'd5;
    cyc("seq5", 1, 1, 0, 0, 0, 0, 2'd0, 32'd6);
    bus.pc_cur = 32'hFFFF_FFFF;
    cyc("seq_wrap", 1, 1, 0, 0, 0, 0, 2'd0, 32'd0);
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
    bus.pc_cur = 32'd10;
    cyc("lu_hazard", 0, 0, 0, 0, 1, 0, 2'd0, 32'd0);
    cyc("lu_stall", 1, 1, 0, 0, 0, 0, 2'd1, 32'd11);
    set_def(); bus.pc_cur = 32'd11;
    cyc("lu_back_run", 1, 1, 0, 0, 0, 0, 2'd0, 32'd12);
    bus.idex_memread = 1'b1; bus.pc_cur = 32'd12;
    cyc("lu_rt_zero", 1, 1, 0, 0, 0, 0, 2'd0, 32'd13);
    bus.idex_rt = 5'd3; bus.ifid_rs = 5'd4; bus.ifid_rt = 5'd3;
    bus.pc_cur = 32'd13;
    cyc("lu_rt_match", 0, 0, 0, 0, 1, 0, 2'd0, 32'd0);
    set_def(); bus.pc_cur = 32'd13;
    cyc("lu_rt_stall", 1, 1, 0, 0, 0, 0, 2'd1, 32'd14);
    set_def();
    bus.pcsrc = 1'b1; bus.branch_add = 32'd20;
    bus.jump = 1'b1; bus.jump_add = 26'd12; bus.pc_cur = 32'd30;
    cyc("br_over_j", 1, 1, 1, 1, 0, 0, 2'd0, 32'd20);
    set_def();
    bus.jump = 1'b1; bus.jump_add = 26'd12; bus.pc_cur = 32'hA000_0005;
    cyc("jump_hi", 1, 1, 1, 0, 0, 0, 2'd0, 32'hA000_0030);
    bus.pc_cur = 32'd0; bus.imem_ready = 1'b0;
    cyc("j_slow", 0, 1, 1, 0, 0, 0, 2'd0, 32'd0);
    bus.jump = 1'b0;
    cyc("j_wait1", 0, 1, 1, 0, 0, 0, 2'd2, 32'd0);
    cyc("j_wait2", 0, 1, 1, 0, 0, 0, 2'd2, 32'd0);
    bus.imem_ready = 1'b1;
    cyc("j_ready", 1, 1, 1, 0, 0, 0, 2'd2, 32'd48);
    bus.pc_cur = 32'd48;
    cyc("j_cleared", 1, 1, 0, 0, 0, 0, 2'd0, 32'd49);
    bus.pc_cur = 32'd49; bus.imem_ready = 1'b0;
    cyc("seq_slow", 0, 1, 1, 0, 0, 0, 2'd0, 32'd0);
    bus.pcsrc = 1'b1; bus.branch_add = 32'd9;
    cyc("br_in_wait", 0, 1, 1, 1, 0, 0, 2'd2, 32'd0);
    bus.pcsrc = 1'b0; bus.jump = 1'b1; bus.jump_add = 26'd12;
    cyc("j_no_ovr", 0, 1, 1, 0, 0, 0, 2'd2, 32'd0);
    bus.jump = 1'b0; bus.imem_ready = 1'b1;
    cyc("br_ready", 1, 1, 1, 0, 0, 0, 2'd2, 32'd9);
    bus.pc_cur = 32'd9;
    cyc("br_cleared", 1, 1, 0, 0, 0, 0, 2'd0, 32'd10);
    bus.pc_cur = 32'd100; bus.imem_ready = 1'b0;
    cyc("wd_enter", 0, 1, 1, 0, 0, 0, 2'd0, 32'd0);
    for (int i = 1; i <= 15; i++)
      cyc($sformatf("wd_wait%0d", i), 0, 1, 1, 0, 0, 0, 2'd2, 32'd0);
    cyc("wd_err", 0, 1, 1, 0, 0, 1, 2'd2, 32'd0);
    bus.imem_ready = 1'b1;
    cyc("wd_ready", 1, 1, 0, 0, 0, 1, 2'd2, 32'd101);
    bus.pc_cur = 32'd101;
    cyc("wd_sticky", 1, 1, 0, 0, 0, 1, 2'd0, 32'd102);
    bus.pc_cur = 32'd102; bus.jump = 1'b1; bus.jump_add = 26'd5;
    bus.imem_ready = 1'b0;
    cyc("rst_pend", 0, 1, 1, 0, 0, 1, 2'd0, 32'd0);
    bus.jump = 1'b0;
    cyc("rst_wait", 0, 1, 1, 0, 0, 1, 2'd2, 32'd0);
    rst = 1'b1;
    cyc("rst_mid", 0, 0, 1, 0, 1, 0, 2'd0, 32'd0);
    rst = 1'b0; set_def(); bus.pc_cur = 32'd7;
    cyc("rst_drop", 1, 1, 0, 0, 0, 0, 2'd0, 32'd8);
`ifdef FETCH_PERF_CNT_EN
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
    bus.pc_cur = 32'd8;
    cyc("pf_hazard", 0, 0, 0, 0, 1, 0, 2'd0, 32'd0);
    set_def(); bus.pc_cur = 32'd8;
    cyc("pf_stall", 1, 1, 0, 0, 0, 0, 2'd1, 32'd9);
    bus.pc_cur = 32'd9; bus.imem_ready = 1'b0;
    cyc("pf_slow", 0, 1, 1, 0, 0, 0, 2'd0, 32'd0);
    cyc("pf_wait", 0, 1, 1, 0, 0, 0, 2'd2, 32'd0);
    bus.imem_ready = 1'b1;
    cyc("pf_wait_rdy", 1, 1, 0, 0, 0, 0, 2'd2, 32'd10);
    bus.pc_cur = 32'd10; bus.jump = 1'b1; bus.jump_add = 26'd3;
    cyc("pf_jump", 1, 1, 1, 0, 0, 0, 2'd0, 32'd12);
    total++;
    if (stall_cnt !== 16'd3) begin
      bad++;
      $display("FAIL stall_cnt act=%0d exp=3", stall_cnt);
    end
    total++;
    if (flush_cnt !== 16'd1) begin
      bad++;
      $display("FAIL flush_cnt act=%0d exp=1", flush_cnt);
    end
    set_def(); bus.pc_cur = 32'd12;
    cyc("pf_idle", 1, 1, 0, 0, 0, 0, 2'd0, 32'd13);
`endif
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending act=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
